// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared parameters, derived widths and FSM states for the band mixer
package eq_pkg;
  localparam int N_BANDS = 8;
  localparam int IN_W    = 32;
  localparam int GAIN_W  = 8;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 20;
  localparam logic [GAIN_W-1:0] GAIN_RST = 8'd32;

  localparam int IDX_W = $clog2(N_BANDS);
  localparam int ACC_W = IN_W + GAIN_W + 1 + IDX_W;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
endpackage

// File: rtl/eq_band_mixer_if.sv
// rtl/eq_band_mixer_if.sv - sample, gain-write and result signals of the band mixer
interface eq_band_mixer_if;
  import eq_pkg::*;

  logic                        in_valid;
  logic [N_BANDS*IN_W-1:0]     band_in;
  logic                        in_ready;
  logic                        gain_we;
  logic [IDX_W-1:0]            gain_addr;
  logic [GAIN_W-1:0]           gain_wdata;
  logic                        out_valid;
  logic signed [OUT_W-1:0]     out_sample;
  logic                        out_sat;
  logic                        overrun;

  modport master (
    output in_valid, band_in, gain_we, gain_addr, gain_wdata,
    input  in_ready, out_valid, out_sample, out_sat, overrun
  );

  modport slave (
    input  in_valid, band_in, gain_we, gain_addr, gain_wdata,
    output in_ready, out_valid, out_sample, out_sat, overrun
  );
endinterface

// File: rtl/eq_round_sat.sv
// rtl/eq_round_sat.sv - round-half-up, arithmetic shift and saturation of the accumulator
module eq_round_sat
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sat
);
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // one guard bit so adding the rounding constant can never wrap
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] r;

  assign rounded = {acc[ACC_W-1], acc} + HALF;
  assign r       = rounded >>> SHIFT;

  always_comb begin
    sat    = 1'b0;
    sample = r[OUT_W-1:0];
    if (r > MAXV) begin
      sat    = 1'b1;
      sample = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < MINV) begin
      sat    = 1'b1;
      sample = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - gain-weighted sum of the equalizer bands through one shared MAC
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  eq_band_mixer_if.slave bus
);
  localparam int PROD_W = IN_W + GAIN_W + 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [IN_W-1:0]  snap  [N_BANDS];
  logic [GAIN_W-1:0]       gsnap [N_BANDS];
  logic [GAIN_W-1:0]       gain  [N_BANDS];
  logic signed [PROD_W-1:0] prod;
  logic signed [OUT_W-1:0] rs_sample;
  logic                    rs_sat;

  // gains are unsigned, so a zero sign bit is prepended before the signed multiply
  assign prod = PROD_W'(snap[idx]) * PROD_W'($signed({1'b0, gsnap[idx]}));

  eq_round_sat u_round_sat (
    .acc    (acc),
    .sample (rs_sample),
    .sat    (rs_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_BANDS; k++) gain[k] <= GAIN_RST;
    end else if (bus.gain_we) begin
      gain[bus.gain_addr] <= bus.gain_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_sample <= '0;
      bus.out_sat    <= 1'b0;
      bus.overrun    <= 1'b0;
      acc            <= '0;
      idx            <= '0;
      for (int k = 0; k < N_BANDS; k++) begin
        snap[k]  <= '0;
        gsnap[k] <= '0;
      end
    end else begin
      bus.out_valid <= 1'b0;
      if (bus.in_valid && !bus.in_ready) bus.overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int k = 0; k < N_BANDS; k++) begin
              snap[k]  <= $signed(bus.band_in[k*IN_W +: IN_W]);
              gsnap[k] <= gain[k];
            end
            acc          <= '0;
            idx          <= '0;
            bus.in_ready <= 1'b0;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= acc + {{IDX_W{prod[PROD_W-1]}}, prod};
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(N_BANDS-1)) state <= OUT;
        end
        OUT: begin
          bus.out_sample <= rs_sample;
          bus.out_sat    <= rs_sat;
          bus.out_valid  <= 1'b1;
          bus.in_ready   <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - directed and randomized checks of eq_band_mixer against a sum-of-products model
module tb_eq_band_mixer;
  import eq_pkg::*;

  typedef logic [IN_W-1:0] bands_t [N_BANDS];
  typedef struct {
    int                      due;
    logic signed [OUT_W-1:0] s;
    logic                    sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  eq_band_mixer_if bus();

  eq_band_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  int   cyc = 0;
  int   busy_until = 0;
  logic m_ov = 1'b0;
  int   m_gain [N_BANDS];
  exp_t exp_q [$];
  logic signed [OUT_W-1:0] last_s = '0;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Reference: plain integer sum of band*gain, then round-half-up and clip.
  function automatic exp_t model_result(input logic [N_BANDS*IN_W-1:0] bi, input int due);
    exp_t   e;
    longint sum = 0;
    longint r;
    for (int k = 0; k < N_BANDS; k++)
      sum += longint'($signed(bi[k*IN_W +: IN_W])) * longint'(m_gain[k]);
    r = (sum + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
    e.due = due;
    e.sat = 1'b0;
    if (r > 32767) begin
      e.s = 16'sd32767; e.sat = 1'b1;
    end else if (r < -32768) begin
      e.s = -16'sd32768; e.sat = 1'b1;
    end else begin
      e.s = OUT_W'(r);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      busy_until = 0;
      m_ov = 1'b0;
      for (int k = 0; k < N_BANDS; k++) m_gain[k] = 32;
    end else begin
      if (bus.in_valid) begin
        if (cyc >= busy_until) begin
          exp_q.push_back(model_result(bus.band_in, cyc + N_BANDS + 1));
          busy_until = cyc + N_BANDS + 2;
        end else begin
          m_ov = 1'b1;
        end
      end
      if (bus.gain_we) m_gain[bus.gain_addr] = int'(bus.gain_wdata);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last_s = '0;
    end else begin
      logic ev;
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
        chk("out_sample", bus.out_sample, exp_q[0].s);
        chk("out_sat", bus.out_sat, exp_q[0].sat);
        last_s = exp_q[0].s;
        void'(exp_q.pop_front());
      end else begin
        chk("out_sample_hold", bus.out_sample, last_s);
      end
      chk("in_ready", bus.in_ready, (cyc + 1 >= busy_until));
      chk("overrun", bus.overrun, m_ov);
    end
  end

  function automatic logic [N_BANDS*IN_W-1:0] pack(input bands_t b);
    logic [N_BANDS*IN_W-1:0] p;
    for (int k = 0; k < N_BANDS; k++) p[k*IN_W +: IN_W] = b[k];
    return p;
  endfunction

  function automatic bands_t single(input int k, input logic [IN_W-1:0] v);
    bands_t b;
    for (int i = 0; i < N_BANDS; i++) b[i] = '0;
    b[k] = v;
    return b;
  endfunction

  function automatic bands_t all_same(input logic [IN_W-1:0] v);
    bands_t b;
    for (int i = 0; i < N_BANDS; i++) b[i] = v;
    return b;
  endfunction

  task automatic send_now(input bands_t b);
    bus.band_in  = pack(b);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input bands_t b);
    @(negedge clk);
    send_now(b);
  endtask

  task automatic set_gain(input int a, input int v);
    @(negedge clk);
    bus.gain_we    = 1'b1;
    bus.gain_addr  = IDX_W'(a);
    bus.gain_wdata = GAIN_W'(v);
    @(negedge clk);
    bus.gain_we    = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < N_BANDS; k++) set_gain(k, v);
  endtask

  task automatic wait_out(output logic signed [OUT_W-1:0] s, output logic sat, output int lat);
    logic seen = 1'b0;
    s = '0; sat = 1'b0; lat = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) begin
        s = bus.out_sample; sat = bus.out_sat; seen = 1'b1;
      end
    end
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_out: got no out_valid expected one within 40 cycles");
    end
  endtask

  task automatic run(input bands_t b, output logic signed [OUT_W-1:0] s, output logic sat, output int lat);
    send(b);
    wait_out(s, sat, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [OUT_W-1:0] s;
    logic st;
    int   lat;
    int   nv;

    bus.in_valid = 1'b0; bus.band_in = '0;
    bus.gain_we = 1'b0; bus.gain_addr = '0; bus.gain_wdata = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sample", bus.out_sample, 0);
    chk("rst_overrun", bus.overrun, 0);

    run(all_same(32'h0010_0000), s, st, lat);
    chk("unity_latency", lat, 9);
    chk("unity_sample", s, 256);
    chk("unity_sat", st, 0);

    set_gain(0, 64);
    for (int k = 1; k < N_BANDS; k++) set_gain(k, 0);
    run(single(0, 32'(100 << 15)), s, st, lat);
    chk("gain0_sample", s, 200);
    set_gain(3, 16);
    run(single(3, 32'(40 << 15)), s, st, lat);
    chk("gain3_sample", s, 20);

    set_all(32);
    run(single(0, 32'd49152), s, st, lat);
    chk("round_pos_1p5", s, 2);
    run(single(0, 32'hFFFF_4000), s, st, lat);
    chk("round_neg_1p5", s, -1);
    run(single(0, 32'd16384), s, st, lat);
    chk("round_half", s, 1);

    set_gain(0, 255);
    run(single(0, 32'h7FFF_FFFF), s, st, lat);
    chk("sat_hi_sample", s, 32767);
    chk("sat_hi_flag", st, 1);
    run(single(0, 32'h8000_0000), s, st, lat);
    chk("sat_lo_sample", s, -32768);
    chk("sat_lo_flag", st, 1);
    run(single(0, 32'h0010_0000), s, st, lat);
    chk("post_sat_sample", s, 255);
    chk("post_sat_flag", st, 0);

    set_gain(0, 32);
    send(all_same(32'h0010_0000));
    repeat (2) @(negedge clk);
    send_now(all_same(32'h0));
    wait_out(s, st, lat);
    chk("overrun_result", s, 256);
    chk("overrun_flag", bus.overrun, 1);

    send(single(0, 32'h0010_0000));
    @(negedge clk);
    set_gain(0, 64);
    wait_out(s, st, lat);
    chk("gain_during_mac_old", s, 32);
    run(single(0, 32'h0010_0000), s, st, lat);
    chk("gain_during_mac_new", s, 64);
    chk("overrun_sticky", bus.overrun, 1);

    set_gain(0, 32);
    run(single(0, 32'h0030_0000), s, st, lat);
    chk("b2b_first", s, 96);
    send_now(single(0, 32'h0050_0000));
    wait_out(s, st, lat);
    chk("b2b_second", s, 160);
    chk("b2b_latency", lat, 9);

    set_gain(5, 0);
    send(all_same(32'h0010_0000));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    chk("midreset_no_valid", nv, 0);
    chk("midreset_sample", bus.out_sample, 0);
    chk("midreset_overrun", bus.overrun, 0);
    run(all_same(32'h0010_0000), s, st, lat);
    chk("midreset_gains_restored", s, 256);

    repeat (400) begin
      logic [IN_W-1:0] r;
      bands_t b;
      @(negedge clk);
      for (int k = 0; k < N_BANDS; k++) begin
        r = $urandom;
        if ($urandom_range(0, 1) == 1) r = IN_W'($signed(r) >>> $urandom_range(8, 20));
        b[k] = r;
      end
      bus.band_in    = pack(b);
      bus.in_valid   = ($urandom_range(0, 5) == 0);
      bus.gain_we    = ($urandom_range(0, 4) == 0);
      bus.gain_addr  = IDX_W'($urandom_range(0, N_BANDS-1));
      bus.gain_wdata = GAIN_W'($urandom_range(0, 255));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.gain_we  = 1'b0;
    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
